// File: rtl/tff_toggle_scheduler.sv
// Round-robin scheduler sharing one T-flip-flop bank between NREQ requesters.
// Each grant drives a latched toggle mask onto t_out for a latched pulse count.
module tff_toggle_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_mask,
    input  logic [NREQ*CNTW-1:0]  req_cnt,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      t_out,
    output logic                  busy,
    output logic [WIDTH-1:0]      q_shadow
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TOGGLE,
        S_DONE
    } state_t;

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_rr_ptr, w_rr_ptr_next;
    logic [PW-1:0]   r_idx, w_idx_next;
    logic [PW-1:0]   w_sel_idx;
    logic            w_sel_found;
    logic [CNTW-1:0] r_remaining, w_remaining_next;
    logic [WIDTH-1:0] r_mask, w_mask_next;
    logic [WIDTH-1:0] r_t_out, w_t_out_next;
    logic [WIDTH-1:0] r_q_shadow;
    logic [NREQ-1:0] r_gnt, w_gnt_next;
    logic [NREQ-1:0] r_done, w_done_next;

    logic [WIDTH-1:0] w_mask_arr [NREQ];
    logic [CNTW-1:0]  w_cnt_arr  [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_mask_arr[gi] = req_mask[gi*WIDTH +: WIDTH];
            assign w_cnt_arr[gi]  = req_cnt[gi*CNTW +: CNTW];
        end
    endgenerate

    // Circular priority search starting at rr_ptr; first requester found wins.
    always_comb begin
        int cand;
        cand        = 0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = int'(r_rr_ptr) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!w_sel_found && req[cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_rr_ptr_next    = r_rr_ptr;
        w_idx_next       = r_idx;
        w_remaining_next = r_remaining;
        w_mask_next      = r_mask;
        w_gnt_next       = r_gnt;
        w_done_next      = r_done;
        w_t_out_next     = r_t_out;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_gnt_next            = '0;
                    w_gnt_next[w_sel_idx] = 1'b1;
                    w_idx_next            = w_sel_idx;
                    w_mask_next           = w_mask_arr[w_sel_idx];
                    w_remaining_next      = w_cnt_arr[w_sel_idx];
                    w_state_next          = S_TOGGLE;
                end
            end
            S_TOGGLE: begin
                // A zero count passes through here for one grant cycle with no pulses,
                // which keeps done at grant+cnt+1 for every count including zero.
                if (r_remaining == '0) begin
                    w_t_out_next       = '0;
                    w_done_next        = '0;
                    w_done_next[r_idx] = 1'b1;
                    w_state_next       = S_DONE;
                end else begin
                    w_t_out_next     = r_mask;
                    w_remaining_next = r_remaining - CNTW'(1);
                end
            end
            S_DONE: begin
                w_gnt_next    = '0;
                w_done_next   = '0;
                w_t_out_next  = '0;
                w_rr_ptr_next = (r_idx == PW'(NREQ-1)) ? '0 : r_idx + PW'(1);
                w_state_next  = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_remaining <= '0;
            r_mask      <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_t_out     <= '0;
            r_q_shadow  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_idx       <= w_idx_next;
            r_remaining <= w_remaining_next;
            r_mask      <= w_mask_next;
            r_gnt       <= w_gnt_next;
            r_done      <= w_done_next;
            r_t_out     <= w_t_out_next;
            r_q_shadow  <= r_q_shadow ^ r_t_out;
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign t_out    = r_t_out;
    assign busy     = (r_state != S_IDLE);
    assign q_shadow = r_q_shadow;

endmodule

// File: tb/tb_tff_toggle_scheduler.sv
// Directed bench for tff_toggle_scheduler: single, even-count, contention,
// zero-count, mid-burst reset and input-change bursts, plus running invariants.
module tb_tff_toggle_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CNTW  = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_mask;
    logic [NREQ*CNTW-1:0]  req_cnt;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      t_out;
    logic                  busy;
    logic [WIDTH-1:0]      q_shadow;

    int n_checks = 0;
    int n_fail   = 0;

    tff_toggle_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_mask (req_mask),
        .req_cnt  (req_cnt),
        .gnt      (gnt),
        .done     (done),
        .t_out    (t_out),
        .busy     (busy),
        .q_shadow (q_shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic [WIDTH-1:0] mask, input logic [CNTW-1:0] cnt);
        req_mask[idx*WIDTH +: WIDTH] = mask;
        req_cnt[idx*CNTW +: CNTW]    = cnt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Called in the cycle right after the grant edge; walks the whole burst.
    task automatic expect_burst(input string tag, input int idx, input logic [WIDTH-1:0] mask,
                                input int cnt, input logic [WIDTH-1:0] q0);
        logic [NREQ-1:0]  oh;
        logic [WIDTH-1:0] qexp;
        oh   = NREQ'(1) << idx;
        qexp = (cnt % 2 == 1) ? (q0 ^ mask) : q0;
        check_val({tag, " gnt@grant"}, 32'(gnt), 32'(oh));
        check_val({tag, " busy@grant"}, 32'(busy), 32'd1);
        check_val({tag, " t_out@grant"}, 32'(t_out), 32'd0);
        check_val({tag, " done@grant"}, 32'(done), 32'd0);
        for (int i = 0; i < cnt; i++) begin
            tick();
            check_val({tag, " t_out pulse"}, 32'(t_out), 32'(mask));
            check_val({tag, " gnt pulse"}, 32'(gnt), 32'(oh));
            check_val({tag, " done pulse"}, 32'(done), 32'd0);
        end
        tick();
        check_val({tag, " done"}, 32'(done), 32'(oh));
        check_val({tag, " gnt@done"}, 32'(gnt), 32'(oh));
        check_val({tag, " t_out@done"}, 32'(t_out), 32'd0);
        check_val({tag, " busy@done"}, 32'(busy), 32'd1);
        check_val({tag, " q_shadow"}, 32'(q_shadow), 32'(qexp));
        tick();
        check_val({tag, " gnt@idle"}, 32'(gnt), 32'd0);
        check_val({tag, " done@idle"}, 32'(done), 32'd0);
        check_val({tag, " busy@idle"}, 32'(busy), 32'd0);
        $display("burst %s: req %0d mask %02h cnt %0d q_shadow %02h", tag, idx, mask, cnt, q_shadow);
    endtask

    // Running invariants on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check_val("inv gnt onehot0", 32'($onehot0(gnt)), 32'd1);
            check_val("inv done onehot0", 32'($onehot0(done)), 32'd1);
            check_val("inv done within gnt", 32'((done & ~gnt) == '0), 32'd1);
            check_val("inv t_out only toggling", 32'((t_out == '0) || (busy && done == '0)), 32'd1);
        end
    end

    initial begin
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] m3 [NREQ];
        req      = '0;
        req_mask = '0;
        req_cnt  = '0;
        rst_n    = 1'b0;
        tick();
        check_val("reset gnt", 32'(gnt), 32'd0);
        check_val("reset done", 32'(done), 32'd0);
        check_val("reset t_out", 32'(t_out), 32'd0);
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset q_shadow", 32'(q_shadow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request, odd count.
        set_req(0, 8'hA5, 4'd3);
        req = 4'b0001;
        tick();
        expect_burst("single", 0, 8'hA5, 3, 8'h00);
        req = '0;

        // Even count from a cleared bank returns q_shadow to zero.
        do_reset();
        set_req(1, 8'hFF, 4'd2);
        req = 4'b0010;
        tick();
        expect_burst("even", 1, 8'hFF, 2, 8'h00);
        req = '0;

        // Full contention with cnt=1: order 0,1,2,3 then wrap back to 0.
        do_reset();
        m3[0] = 8'h01; m3[1] = 8'h02; m3[2] = 8'h04; m3[3] = 8'h08;
        for (int r = 0; r < NREQ; r++) set_req(r, m3[r], 4'd1);
        req = 4'b1111;
        q   = 8'h00;
        for (int b = 0; b < 5; b++) begin
            tick();
            expect_burst("contend", b % NREQ, m3[b % NREQ], 1, q);
            q = q ^ m3[b % NREQ];
        end
        req = '0;

        // Zero count: no pulses, done one cycle after grant.
        set_req(2, 8'h3C, 4'd0);
        req = 4'b0100;
        tick();
        expect_burst("zero", 2, 8'h3C, 0, q);
        req = '0;

        // Reset in the fifth pulse cycle of a 15-pulse burst clears outputs at once.
        do_reset();
        set_req(0, 8'h5A, 4'd15);
        req = 4'b0001;
        tick();
        for (int i = 0; i < 5; i++) tick();
        check_val("midreset t_out before", 32'(t_out), 32'h5A);
        rst_n = 1'b0;
        #1;
        check_val("midreset t_out", 32'(t_out), 32'd0);
        check_val("midreset gnt", 32'(gnt), 32'd0);
        check_val("midreset busy", 32'(busy), 32'd0);
        check_val("midreset q_shadow", 32'(q_shadow), 32'd0);
        check_val("midreset done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_burst("after reset", 0, 8'h5A, 15, 8'h00);
        req = '0;

        // Inputs changed and req dropped after the grant are ignored for this burst.
        set_req(0, 8'hC3, 4'd4);
        req = 4'b0001;
        tick();
        set_req(0, 8'hFF, 4'd2);
        req = '0;
        expect_burst("latched", 0, 8'hC3, 4, 8'h5A);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
